// File: rtl/mem_arb_pkg.sv
// Shared types and default parameters for the data-memory arbiter (CPU port + video read port).
package mem_arb_pkg;

    localparam int MEM_ARB_ADDR_W   = 16;
    localparam int MEM_ARB_DATA_W   = 32;
    localparam int MEM_ARB_MAX_WAIT = 4;

    // Records which requester owns the read response arriving next cycle.
    typedef enum logic [1:0] {
        OP_IDLE   = 2'd0,
        OP_CPU_RD = 2'd1,
        OP_VID_RD = 2'd2
    } last_op_e;

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Saturating count of consecutive CPU stall cycles; used by the starvation guard
// (only instantiated when MEM_ARB_STARVE_GUARD_EN is defined).
module mem_arb_starve_cnt
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = MEM_ARB_MAX_WAIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_max_o
);

    localparam int              CNT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] cpu_wait_d;
    logic [CNT_W-1:0] cpu_wait_q;

    // Next count: clear wins, otherwise increment until saturated.
    always_comb begin
        cpu_wait_d = cpu_wait_q;
        if (clr_i) begin
            cpu_wait_d = {CNT_W{1'b0}};
        end else if (inc_i && (cpu_wait_q != WAIT_MAX)) begin
            cpu_wait_d = cpu_wait_q + CNT_W'(1);
        end else begin
            cpu_wait_d = cpu_wait_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_wait_q <= {CNT_W{1'b0}};
        end else begin
            cpu_wait_q <= cpu_wait_d;
        end
    end

    assign at_max_o = (cpu_wait_q == WAIT_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter (CPU load/store, video read) onto a single synchronous-read memory.
// Define MEM_ARB_STARVE_GUARD_EN to let a stalled CPU win after MAX_WAIT lost cycles.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = MEM_ARB_ADDR_W,
    parameter int DATA_W   = MEM_ARB_DATA_W,
    parameter int MAX_WAIT = MEM_ARB_MAX_WAIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_gnt,
    output logic              vid_rvalid,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic     cpu_gnt_s;
    logic     vid_gnt_s;
    logic     force_cpu_s;
    last_op_e last_op_d;
    last_op_e last_op_q;

`ifdef MEM_ARB_STARVE_GUARD_EN
    mem_arb_starve_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_cnt (
        .clk      (clk),
        .rst_n    (rst),
        .inc_i    (cpu_req & ~cpu_gnt_s),
        .clr_i    (~cpu_req | cpu_gnt_s),
        .at_max_o (force_cpu_s)
    );
`else
    // Strict video priority: the CPU is never forced through.
    assign force_cpu_s = 1'b0;
`endif

    // Grant decision; the reset input gates all grants so nothing issues while in reset.
    always_comb begin
        cpu_gnt_s = 1'b0;
        vid_gnt_s = 1'b0;
        if (!rst) begin
            cpu_gnt_s = 1'b0;
            vid_gnt_s = 1'b0;
        end else if (cpu_req && (!vid_req || force_cpu_s)) begin
            cpu_gnt_s = 1'b1;
        end else if (vid_req) begin
            vid_gnt_s = 1'b1;
        end else begin
            cpu_gnt_s = 1'b0;
            vid_gnt_s = 1'b0;
        end
    end

    // Memory port mux; address and data are zero when no access is issued.
    always_comb begin
        mem_addr  = {ADDR_W{1'b0}};
        mem_wdata = {DATA_W{1'b0}};
        mem_we    = 1'b0;
        if (cpu_gnt_s) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_we    = cpu_we;
        end else if (vid_gnt_s) begin
            mem_addr  = vid_addr;
        end else begin
            mem_addr  = {ADDR_W{1'b0}};
        end
    end

    // Next owner of the read response; stores produce none.
    always_comb begin
        last_op_d = OP_IDLE;
        if (cpu_gnt_s && !cpu_we) begin
            last_op_d = OP_CPU_RD;
        end else if (vid_gnt_s) begin
            last_op_d = OP_VID_RD;
        end else begin
            last_op_d = OP_IDLE;
        end
    end

    // Response-owner register; reset discards any read still in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_op_q <= OP_IDLE;
        end else begin
            last_op_q <= last_op_d;
        end
    end

    assign cpu_gnt    = cpu_gnt_s;
    assign vid_gnt    = vid_gnt_s;
    assign cpu_stall  = cpu_req & ~cpu_gnt_s;
    assign mem_en     = cpu_gnt_s | vid_gnt_s;
    assign cpu_rvalid = (last_op_q == OP_CPU_RD);
    assign vid_rvalid = (last_op_q == OP_VID_RD);
    assign cpu_rdata  = mem_rdata;
    assign vid_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table vectors, directed corner sequences and random traffic
// against a cycle-level reference model and a small synchronous RAM.
module tb_mem_arbiter;

    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD_ON = 1'b1;
`else
    localparam bit GUARD_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              cpu_req = 1'b0, cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic              cpu_gnt, cpu_stall, cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic              vid_req = 1'b0;
    logic [ADDR_W-1:0] vid_addr = '0;
    logic              vid_gnt, vid_rvalid;
    logic [DATA_W-1:0] vid_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;

    int checks = 0;
    int failures = 0;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .vid_req(vid_req), .vid_addr(vid_addr),
        .vid_gnt(vid_gnt), .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] init_word(input int i);
        return DATA_W'(i) * 32'h0101_0101 + 32'd7;
    endfunction

    // Synchronous-read RAM, 16 words, reloaded while reset is held.
    logic [DATA_W-1:0] ram [0:15];
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) ram[i] <= init_word(i);
            mem_rdata <= '0;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr[3:0]] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr[3:0]];
        end
    end

    // Reference model state: pending response owner (0 none, 1 cpu, 2 vid), its data, stall count.
    logic [DATA_W-1:0] shadow [0:15];
    int                pend = 0;
    logic [DATA_W-1:0] pend_data = '0;
    int                m_wait = 0;
    logic              e_c = 1'b0, e_v = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs after the edge, then check against the model mid-cycle.
    task automatic cycle(input logic r, input logic c_req, input logic c_we,
                         input logic [ADDR_W-1:0] c_addr, input logic [DATA_W-1:0] c_wd,
                         input logic v_req, input logic [ADDR_W-1:0] v_addr);
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_wd;
        @(posedge clk);
        #1;
        rst = r; cpu_req = c_req; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wd;
        vid_req = v_req; vid_addr = v_addr;
        #3;
        e_c = 1'b0; e_v = 1'b0;
        if (r && c_req && (!v_req || (GUARD_ON && m_wait >= MAX_WAIT))) e_c = 1'b1;
        else if (r && v_req) e_v = 1'b1;
        e_addr = e_c ? c_addr : (e_v ? v_addr : '0);
        e_wd   = e_c ? c_wd : '0;
        chk("cpu_gnt",   cpu_gnt,   e_c);
        chk("vid_gnt",   vid_gnt,   e_v);
        chk("cpu_stall", cpu_stall, c_req && !e_c);
        chk("mem_en",    mem_en,    e_c || e_v);
        chk("mem_we",    mem_we,    e_c && c_we);
        chk("mem_addr",  mem_addr,  e_addr);
        chk("mem_wdata", mem_wdata, e_wd);
        chk("cpu_rvalid", cpu_rvalid, r && pend == 1);
        chk("vid_rvalid", vid_rvalid, r && pend == 2);
        if (r && pend == 1) chk("cpu_rdata", cpu_rdata, pend_data);
        if (r && pend == 2) chk("vid_rdata", vid_rdata, pend_data);
        if (!r) begin
            pend = 0; m_wait = 0;
            for (int i = 0; i < 16; i++) shadow[i] = init_word(i);
        end else begin
            pend = (e_c && !c_we) ? 1 : (e_v ? 2 : 0);
            pend_data = shadow[e_addr[3:0]];
            if (e_c && c_we) shadow[c_addr[3:0]] = c_wd;
            m_wait = (c_req && !e_c) ? ((m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT) : 0;
        end
    endtask

    task automatic idle();
        cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    typedef struct {
        logic              c_req, c_we, v_req;
        logic [ADDR_W-1:0] c_addr, v_addr;
        logic [DATA_W-1:0] c_wd;
        logic              x_cg, x_vg, x_we, x_stall;
        logic [ADDR_W-1:0] x_addr;
        logic [DATA_W-1:0] x_wd;
    } vec_t;

    vec_t vecs [8];

    logic              r_creq, r_cwe, r_vreq;
    logic [ADDR_W-1:0] r_caddr, r_vaddr;
    logic [DATA_W-1:0] r_cwd;

    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h1234, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1234, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 16'h0042, 16'h0000, 32'hDEAD, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0042, 32'hDEAD};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 16'h0007, 16'h0000, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0007, 32'hA5A5A5A5};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 16'h0003, 16'h0ABC, 32'h1111, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0ABC, 32'h0};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 16'h0009, 16'h0F0E, 32'h2222, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0F0E, 32'h0};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 16'h0005, 16'h0000, 32'h3333, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 16'h0005, 16'h00C1, 32'h4444, 1'b0, 1'b1, 1'b0, 1'b0, 16'h00C1, 32'h0};

        // Reset state, with requests pending to prove the gating.
        cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        cycle(1'b0, 1'b1, 1'b0, 16'h0001, '0, 1'b1, 16'h0002);
        chk("rst_vid_gnt", vid_gnt, 1'b0);

        // First cycle out of reset grants immediately; load returns 7 one cycle later.
        cycle(1'b1, 1'b1, 1'b0, 16'h0010, 32'h0, 1'b0, '0);
        chk("ld_gnt", cpu_gnt, 1'b1);
        idle();
        chk("ld_rvalid", cpu_rvalid, 1'b1);
        chk("ld_rdata", cpu_rdata, 32'h0000_0007);

        // Store completes in its grant cycle with no response.
        cycle(1'b1, 1'b1, 1'b1, 16'h0020, 32'h5, 1'b0, '0);
        chk("st_en", mem_en, 1'b1);
        chk("st_we", mem_we, 1'b1);
        chk("st_wdata", mem_wdata, 32'h5);
        idle();
        chk("st_no_rvalid", cpu_rvalid, 1'b0);

        foreach (vecs[k]) begin
            cycle(1'b1, vecs[k].c_req, vecs[k].c_we, vecs[k].c_addr, vecs[k].c_wd,
                  vecs[k].v_req, vecs[k].v_addr);
            chk($sformatf("vec%0d_cgnt", k), cpu_gnt, vecs[k].x_cg);
            chk($sformatf("vec%0d_vgnt", k), vid_gnt, vecs[k].x_vg);
            chk($sformatf("vec%0d_we", k), mem_we, vecs[k].x_we);
            chk($sformatf("vec%0d_stall", k), cpu_stall, vecs[k].x_stall);
            chk($sformatf("vec%0d_addr", k), mem_addr, vecs[k].x_addr);
            chk($sformatf("vec%0d_wdata", k), mem_wdata, vecs[k].x_wd);
            idle();
        end

        // Contention held for six cycles: the guard lets the CPU through once, at cycle 4.
        idle();
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 16'h0003, '0, 1'b1, 16'h0005);
            chk($sformatf("starve_vgnt%0d", i), vid_gnt, (GUARD_ON && i == 4) ? 1'b0 : 1'b1);
            chk($sformatf("starve_cgnt%0d", i), cpu_gnt, (GUARD_ON && i == 4) ? 1'b1 : 1'b0);
            chk($sformatf("starve_stall%0d", i), cpu_stall, (GUARD_ON && i == 4) ? 1'b0 : 1'b1);
        end
        idle();

        // Reset during an outstanding video read throws the response away.
        cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 16'h0004);
        chk("rr_vgnt", vid_gnt, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 16'h0004);
        chk("rr_rvalid_in_rst", vid_rvalid, 1'b0);
        chk("rr_en_in_rst", mem_en, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        idle();
        chk("rr_rvalid_after", vid_rvalid, 1'b0);

        // Alternating reads: each response goes only to the requester granted the cycle before.
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, ADDR_W'(i));
            else            cycle(1'b1, 1'b1, 1'b0, ADDR_W'(i), '0, 1'b0, '0);
            if (i > 0) begin
                chk($sformatf("alt_cpu_rv%0d", i), cpu_rvalid, (i % 2 == 0) ? 1'b1 : 1'b0);
                chk($sformatf("alt_vid_rv%0d", i), vid_rvalid, (i % 2 == 1) ? 1'b1 : 1'b0);
            end
        end
        idle();

        // Random traffic; each requester holds its request until the model says it was granted.
        r_creq = 1'b0; r_vreq = 1'b0; r_cwe = 1'b0; r_caddr = '0; r_vaddr = '0; r_cwd = '0;
        for (int n = 0; n < 400; n++) begin
            if (!r_creq || e_c) begin
                r_creq  = ($urandom_range(0, 2) != 0);
                r_cwe   = $urandom_range(0, 1) == 1;
                r_caddr = ADDR_W'($urandom);
                r_cwd   = $urandom;
            end
            if (!r_vreq || e_v) begin
                r_vreq  = $urandom_range(0, 1) == 1;
                r_vaddr = ADDR_W'($urandom);
            end
            cycle(1'b1, r_creq, r_cwe, r_caddr, r_cwd, r_vreq, r_vaddr);
            chk("rand_onehot", {63'd0, cpu_gnt & vid_gnt}, 64'd0);
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, word address width of the shared data memory.
REQ-002 Parameter DATA_W, default 32, data word width.
REQ-003 Parameter MAX_WAIT, default 4, CPU wait cycles tolerated before forced CPU grant.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-low (0 = reset).
REQ-006 cpu_req / cpu_we  in  1 / 1  processor access request / write enable (1 = store, 0 = load).
REQ-007 cpu_addr / cpu_wdata  in  ADDR_W / DATA_W  processor address / store data.
REQ-008 cpu_gnt / cpu_stall  out  1 / 1  access issued this cycle / cpu_req & ~cpu_gnt.
REQ-009 cpu_rvalid / cpu_rdata  out  1 / DATA_W  load data valid / load data.
REQ-010 vid_req / vid_addr  in  1 / ADDR_W  pixel-reader read request / address (read-only requester).
REQ-011 vid_gnt / vid_rvalid / vid_rdata  out  1 / 1 / DATA_W  grant, read valid, read data.
REQ-012 mem_en / mem_we  out  1 / 1  memory enable / write enable.
REQ-013 mem_addr / mem_wdata  out  ADDR_W / DATA_W  memory address / write data.
REQ-014 mem_rdata  in  DATA_W  synchronous-read data, valid one cycle after mem_en & ~mem_we.

Function
REQ-015 Arbitration combinational each cycle; grant asserted in the same cycle the access drives the mem_* outputs.
REQ-016 At most one of cpu_gnt, vid_gnt high per cycle; mem_en = cpu_gnt | vid_gnt.
REQ-017 Only vid_req: vid_gnt=1, mem_we=0, mem_addr=vid_addr.
REQ-018 Only cpu_req: cpu_gnt=1, mem_we=cpu_we, mem_addr=cpu_addr, mem_wdata=cpu_wdata.
REQ-019 Both requesting: vid wins unless starvation guard fires (REQ-030).
REQ-020 Requester holds req/addr/we/wdata stable until its grant; back-to-back grants to the same requester allowed every cycle.
REQ-021 FSM register last_op in {IDLE, CPU_RD, VID_RD}: next = CPU_RD on cpu_gnt & ~cpu_we, VID_RD on vid_gnt, else IDLE (CPU writes go to IDLE).
REQ-022 cpu_rvalid = (last_op == CPU_RD); vid_rvalid = (last_op == VID_RD); read latency exactly 1 cycle after grant.
REQ-023 cpu_rdata and vid_rdata both driven from mem_rdata; consumers qualify with their rvalid.
REQ-024 CPU store produces no rvalid; completes in the grant cycle.
REQ-025 Counter cpu_wait (width clog2(MAX_WAIT+1)): +1 each cycle cpu_req & ~cpu_gnt, saturates at MAX_WAIT; cleared on cpu_gnt or ~cpu_req.
REQ-026 mem_wdata = cpu_wdata whenever cpu_gnt; 0 otherwise.

Reset
REQ-027 While rst=0: last_op=IDLE, cpu_wait=0, all grants, rvalids, mem_en, mem_we forced 0; mem_addr, mem_wdata 0.
REQ-028 Reset asserted mid-transaction discards pending read response: no rvalid in the cycle after rst deasserts.
REQ-029 First grant possible in first cycle with rst=1.

Configuration
REQ-030 Macro MEM_ARB_STARVE_GUARD_EN defined: both requesting and cpu_wait == MAX_WAIT -> cpu_gnt=1, vid_gnt=0.
REQ-031 Macro undefined: strict video priority; cpu_wait counter not instantiated; CPU may stall indefinitely.

Structure
REQ-032 Package mem_arb_pkg holds last_op enum type and ADDR_W/DATA_W/MAX_WAIT defaults.
REQ-033 Sub-module mem_arb_starve_cnt holds the saturating wait counter, compiled only under MEM_ARB_STARVE_GUARD_EN.

Verification
REQ-034 cpu_req=1,we=0,addr=0x0010, mem returns 0x00000007 -> cpu_gnt same cycle, cpu_rvalid=1 with rdata=0x7 next cycle.
REQ-035 cpu_req=1,we=1,addr=0x0020,wdata=0x5 -> mem_en=1,mem_we=1,mem_wdata=0x5 same cycle, cpu_rvalid stays 0.
REQ-036 vid_req and cpu_req both held from cycle 0, guard enabled, MAX_WAIT=4 -> vid_gnt cycles 0-3, cpu_gnt cycle 4, vid_gnt cycle 5.
REQ-037 Same stimulus, guard disabled -> vid_gnt every cycle, cpu_stall=1 throughout.
REQ-038 vid read granted, rst pulled low next cycle for 2 cycles -> all outputs 0 during reset, vid_rvalid=0 after release.
REQ-039 Alternating vid/cpu reads back-to-back -> rvalid routed to correct requester each cycle, never both high.
